uart_receiver: RTL
==================

# uart_receiver

Serial-to-parallel UART receiver: 8 data bits, no parity, 1 stop bit, LSB first. It is the receive-side counterpart of the team's UART transmitter and sits on the same system clock. It synchronises the asynchronous `rx` line and derives bit timing from an internal counter, so no external baud tick is needed. It presents each received byte with a sticky ready flag, plus framing-error and overrun status.

## Interface
- `CLKS_PER_BIT`, default 434, is the system clocks per bit (50 MHz / 115200). Legal values are ≥ 4.
- `HALF` is a derived localparam equal to `CLKS_PER_BIT/2` (floor). It is not overridable.

- `clk50`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `rx`  in  1  serial line, asynchronous to `clk50`, idles high
- `rdy_clr`  in  1  one-cycle pulse acknowledging `dout`; clears `rdy`, `overrun`, `frame_err`
- `dout`  out  8  last correctly framed byte
- `rdy`  out  1  sticky; new byte available in `dout`
- `frame_err`  out  1  sticky; last frame had a low stop bit
- `overrun`  out  1  sticky; a byte completed while `rdy` was already 1
- `rx_busy`  out  1  high whenever the FSM is not in IDLE (combinational from state)

## Operation
- Input conditioning:
  - `rx` passes through two flops (`rx_s`), then one more (`rx_prev`). All three reset to 1.
  - A start condition requires `rx_prev==1 && rx_s==0`, i.e. a falling edge.
- The FSM has four states: IDLE, START, DATA and STOP. A cycle counter `cnt` and a 3-bit `bitpos` drive it.
- **IDLE:** on a falling edge, go to START with `cnt<=0`.
- **START:** `cnt` increments each cycle. When `cnt==HALF-1`:
  - If `rx_s==0`, go to DATA with `cnt<=0` and `bitpos<=0`.
  - Otherwise it was a glitch: return to IDLE with no output change.
- **DATA:** when `cnt==CLKS_PER_BIT-1`:
  - Do `shreg[bitpos]<=rx_s` and `cnt<=0`.
  - If `bitpos==7`, go to STOP. Otherwise increment `bitpos`.
  - In all other cycles, `cnt` increments.
- **STOP:** when `cnt==CLKS_PER_BIT-1`, always return to IDLE.
  - If `rx_s==1` (good frame):
    - `dout<=shreg`, `rdy<=1`, `frame_err<=0`.
    - If `rdy` was already 1 and `rdy_clr` is low this cycle, `overrun<=1`.
    - `dout` is overwritten regardless.
  - If `rx_s==0` (bad frame):
    - `frame_err<=1`.
    - `dout` and `rdy` are unchanged.
    - A new frame needs a fresh falling edge, so a held-low break line does not retrigger reception.
- **`rdy_clr`:** clears `rdy`, `overrun` and `frame_err` on the next edge.
  - If it coincides with a good-frame completion, the completion wins: `rdy` stays 1, `overrun` is not set, `frame_err` is 0.
  - If it coincides with a bad-frame completion, `frame_err` is 1 and `rdy` is cleared.
- **Reset** (asserted at any time, including mid-frame):
  - Immediately forces IDLE, with `cnt`, `bitpos` and `shreg` at 0.
  - `dout=8'h00`, `rdy=0`, `frame_err=0`, `overrun=0`, `rx_busy=0`.
  - Synchroniser flops go to 1.
  - After release, a line already low does not start a frame until it has been seen high.

## Timing
Let e0 be the first `clk50` edge at which `rx` is low, i.e. the start-bit leading edge.
- `rx_s` is low after e1, and the FSM enters START at e2.
- Start-bit check is at e(2+HALF).
- Data bit k is sampled at e(2+HALF+(k+1)·CLKS_PER_BIT), for k = 0..7.
- Stop-bit check is at e(2+HALF+9·CLKS_PER_BIT). `rdy` and `dout` are valid after that edge.
  - With the default values this is e4125.
- `rx_busy` rises after e2 and falls after the stop-check edge.
- Back-to-back frames are supported. The next start edge can be detected as soon as the FSM is back in IDLE, which is about half a bit before the stop bit ends.
- Sample points stay within ±1 clock of bit centre, giving tolerance of about ±4% baud mismatch at the default `CLKS_PER_BIT`.

## Test plan
Use `CLKS_PER_BIT=16` (`HALF=8`).
- **Reset state:** hold `rst_n=0`, `rx=1`, then release. Expect `dout=00`, `rdy=0`, `frame_err=0`, `overrun=0`, `rx_busy=0`.
- **Single byte:** drive byte 0xA5 with start edge at e0. Expect `rdy` to rise after e154 (2+8+144), `dout=A5`, `frame_err=0`. Then pulse `rdy_clr`: `rdy=0` on the next edge.
- **Glitch rejection:** pulse `rx` low for 3 cycles. Expect `rx_busy` high for 8 cycles, then low. `rdy` stays 0 and `dout` is unchanged.
- **Framing error and break:**
  - Send 0x3C with stop bit 0. Expect `frame_err=1`, `rdy=0`, `dout` unchanged.
  - Hold `rx` low for 400 cycles. Expect no further frame.
  - Raise `rx`, then send 0x81. Expect `dout=81`, `rdy=1`, `frame_err=0`.
- **Overrun and simultaneity:**
  - Send 0x11 then 0x22 back-to-back without `rdy_clr`. Expect `dout=22`, `overrun=1`.
  - Repeat with `rdy_clr` pulsed exactly on the second stop-check edge. Expect `rdy=1`, `overrun=0`.
- **Reset mid-frame:** assert `rst_n=0` during data bit 4 of 0xF0, release with `rx=1`, then send 0x5A. Expect all outputs at reset values after reset, then `dout=5A` with no corruption.

Source files
------------

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: bundles the UART receive line, the byte-acknowledge pulse and
// the receiver status/data outputs.
//   rx        serial line into the receiver (idles high)
//   rdy_clr   one-cycle acknowledge of dout; clears rdy/overrun/frame_err
//   dout      last correctly framed byte
//   rdy       sticky new-byte flag
//   frame_err sticky low-stop-bit flag
//   overrun   sticky byte-lost flag
//   rx_busy   receiver is mid-frame
// The master modport is the side that drives the line and consumes bytes;
// the slave modport is the receiver itself.
interface uart_receiver_if;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        output rx,
        output rdy_clr,
        input  dout,
        input  rdy,
        input  frame_err,
        input  overrun,
        input  rx_busy
    );

    modport slave (
        input  rx,
        input  rdy_clr,
        output dout,
        output rdy,
        output frame_err,
        output overrun,
        output rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, with internal bit timing.
// Ports:
//   i_clk50   system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   io_uart   uart_receiver_if.slave (rx, rdy_clr in; dout, rdy, frame_err,
//             overrun, rx_busy out)
// Parameter CLKS_PER_BIT (>= 4) is clocks per bit; HALF is its floor half.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic            i_clk50,
    input  logic            i_rst_n,
    uart_receiver_if.slave  io_uart
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Input conditioning
    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_prev;
    // r_valid[1] set once r_rx_s holds a real sample rather than its reset value
    logic [1:0] r_valid;
    // Line has genuinely been observed high since reset; blocks a start on a
    // line that was already low when reset was released
    logic       r_seen_high;
    logic       w_fall;

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_bitpos, w_bitpos_next;
    logic [7:0]      r_shreg, w_shreg_next;
    logic [7:0]      r_dout, w_dout_next;
    logic            r_rdy, w_rdy_next;
    logic            r_ferr, w_ferr_next;
    logic            r_ovr, w_ovr_next;

    assign w_fall = r_seen_high & r_rx_prev & ~r_rx_s;

    always_ff @(posedge i_clk50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_valid     <= 2'b00;
            r_seen_high <= 1'b0;
        end else begin
            r_rx_meta   <= io_uart.rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_rx_s;
            r_valid     <= {r_valid[0], 1'b1};
            r_seen_high <= r_seen_high | (r_valid[1] & r_rx_s);
        end
    end

    always_ff @(posedge i_clk50 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_bitpos <= '0;
            r_shreg  <= '0;
            r_dout   <= '0;
            r_rdy    <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_bitpos <= w_bitpos_next;
            r_shreg  <= w_shreg_next;
            r_dout   <= w_dout_next;
            r_rdy    <= w_rdy_next;
            r_ferr   <= w_ferr_next;
            r_ovr    <= w_ovr_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_bitpos_next = r_bitpos;
        w_shreg_next  = r_shreg;
        w_dout_next   = r_dout;
        w_rdy_next    = r_rdy;
        w_ferr_next   = r_ferr;
        w_ovr_next    = r_ovr;

        // Acknowledge first so a coinciding frame completion below overrides it
        if (io_uart.rdy_clr) begin
            w_rdy_next  = 1'b0;
            w_ferr_next = 1'b0;
            w_ovr_next  = 1'b0;
        end

        unique case (r_state)
            StIdle: begin
                if (w_fall) begin
                    w_state_next = StStart;
                    w_cnt_next   = '0;
                end
            end
            StStart: begin
                if (r_cnt == CntHalf) begin
                    w_cnt_next = '0;
                    if (!r_rx_s) begin
                        w_state_next  = StData;
                        w_bitpos_next = '0;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StData: begin
                if (r_cnt == CntLast) begin
                    w_shreg_next[r_bitpos] = r_rx_s;
                    w_cnt_next             = '0;
                    if (r_bitpos == 3'd7) begin
                        w_state_next = StStop;
                    end else begin
                        w_bitpos_next = r_bitpos + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            StStop: begin
                if (r_cnt == CntLast) begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                    if (r_rx_s) begin
                        w_dout_next = r_shreg;
                        w_rdy_next  = 1'b1;
                        w_ferr_next = 1'b0;
                        if (r_rdy && !io_uart.rdy_clr) begin
                            w_ovr_next = 1'b1;
                        end
                    end else begin
                        w_ferr_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign io_uart.dout      = r_dout;
    assign io_uart.rdy       = r_rdy;
    assign io_uart.frame_err = r_ferr;
    assign io_uart.overrun   = r_ovr;
    assign io_uart.rx_busy   = (r_state != StIdle);

endmodule
